// File: rtl/relay_register_bank.sv
// Relay-computer register bank: NUM_REGS registers loaded from ALU or data bus
// after a programmable settle delay, with a registered single-register bus select.
module relay_register_bank #(
  parameter int N             = 8,
  parameter int NUM_REGS      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          alu_result,
  input  logic [N-1:0]          bus_in,
  input  logic [NUM_REGS-1:0]   ld,
  input  logic [NUM_REGS-1:0]   src_alu,
  input  logic [NUM_REGS-1:0]   sel,
  output logic [N-1:0]          bus_out,
  output logic                  bus_drive,
  output logic                  sel_conflict,
  output logic                  busy,
  output logic                  ld_dropped,
  output logic [NUM_REGS-1:0]   led_ld,
  output logic [NUM_REGS-1:0]   led_sel,
  output logic [NUM_REGS*N-1:0] regs_flat
);

  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic [NUM_REGS-1:0]   src_q, src_d;
  logic [N-1:0]          stage_alu_q, stage_alu_d;
  logic [N-1:0]          stage_bus_q, stage_bus_d;
  logic [N-1:0]          regs_q [NUM_REGS];
  logic [N-1:0]          regs_d [NUM_REGS];
  logic                  ld_dropped_q, ld_dropped_d;
  logic [N-1:0]          bus_out_q, bus_out_d;
  logic                  bus_drive_q, bus_drive_d;
  logic                  sel_conflict_q, sel_conflict_d;
  logic [NUM_REGS-1:0]   led_sel_q, led_sel_d;

  logic                  sel_onehot;
  logic [N-1:0]          sel_val;

  // Load FSM: sample sources on the request edge, commit after the settle delay.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    src_d        = src_q;
    stage_alu_d  = stage_alu_q;
    stage_bus_d  = stage_bus_q;
    regs_d       = regs_q;
    ld_dropped_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld != '0) begin
          pend_d      = ld;
          src_d       = src_alu;
          stage_alu_d = alu_result;
          stage_bus_d = bus_in;
          cnt_d       = 4'(SETTLE_CYCLES - 1);
          state_d     = (SETTLE_CYCLES > 1) ? SETTLE : COMMIT;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = COMMIT;
      end
      COMMIT: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (pend_q[i]) regs_d[i] = src_q[i] ? stage_alu_q : stage_bus_q;
        end
        pend_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && ld != '0) ld_dropped_d = 1'b1;
  end

  // Bus select reads contents as held before the edge, so a commit is seen one select later.
  always_comb begin
    sel_onehot = (sel != '0) && ((sel & (sel - NUM_REGS'(1))) == '0);
    sel_val    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) sel_val = sel_val | regs_q[i];
    end
    bus_out_d      = sel_onehot ? sel_val : '0;
    bus_drive_d    = sel_onehot;
    sel_conflict_d = (sel != '0) && !sel_onehot;
    led_sel_d      = sel;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pend_q         <= '0;
      src_q          <= '0;
      stage_alu_q    <= '0;
      stage_bus_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      ld_dropped_q   <= 1'b0;
      bus_out_q      <= '0;
      bus_drive_q    <= 1'b0;
      sel_conflict_q <= 1'b0;
      led_sel_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      src_q          <= src_d;
      stage_alu_q    <= stage_alu_d;
      stage_bus_q    <= stage_bus_d;
      regs_q         <= regs_d;
      ld_dropped_q   <= ld_dropped_d;
      bus_out_q      <= bus_out_d;
      bus_drive_q    <= bus_drive_d;
      sel_conflict_q <= sel_conflict_d;
      led_sel_q      <= led_sel_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*N +: N] = regs_q[i];
  end

  assign busy         = (state_q != IDLE);
  assign led_ld       = pend_q;
  assign ld_dropped   = ld_dropped_q;
  assign bus_out      = bus_out_q;
  assign bus_drive    = bus_drive_q;
  assign sel_conflict = sel_conflict_q;
  assign led_sel      = led_sel_q;

endmodule

// File: tb/tb_relay_register_bank.sv
// Self-checking bench for relay_register_bank: load latency, busy drop,
// bus select table through a scoreboard, and reset abort with SETTLE_CYCLES=3.
module tb_relay_register_bank;

  logic       clk = 1'b0;
  logic       reset, reset3;
  logic [7:0] alu_result, bus_in;
  logic [3:0] ld, src_alu, sel;

  logic [7:0]  bus_out, d3_bus_out;
  logic        bus_drive, sel_conflict, busy, ld_dropped;
  logic        d3_bus_drive, d3_sel_conflict, d3_busy, d3_ld_dropped;
  logic [3:0]  led_ld, led_sel, d3_led_ld, d3_led_sel;
  logic [31:0] regs_flat, d3_regs_flat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] bus;
    logic       drive;
    logic       conf;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] bus;
    logic       drive;
    logic       conf;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  relay_register_bank #(.N(8), .NUM_REGS(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .alu_result(alu_result), .bus_in(bus_in),
    .ld(ld), .src_alu(src_alu), .sel(sel), .bus_out(bus_out),
    .bus_drive(bus_drive), .sel_conflict(sel_conflict), .busy(busy),
    .ld_dropped(ld_dropped), .led_ld(led_ld), .led_sel(led_sel),
    .regs_flat(regs_flat)
  );

  relay_register_bank #(.N(8), .NUM_REGS(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset3), .alu_result(alu_result), .bus_in(bus_in),
    .ld(ld), .src_alu(src_alu), .sel(sel), .bus_out(d3_bus_out),
    .bus_drive(d3_bus_drive), .sel_conflict(d3_sel_conflict), .busy(d3_busy),
    .ld_dropped(d3_ld_dropped), .led_ld(d3_led_ld), .led_sel(d3_led_sel),
    .regs_flat(d3_regs_flat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_sel(input logic [7:0] b, input logic d, input logic c);
    exp_t e;
    e.bus = b; e.drive = d; e.conf = c;
    sbq.push_back(e);
  endtask

  // One clock edge; any queued select expectation is due on this edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("bus_out", {56'd0, bus_out}, {56'd0, e.bus});
      check("bus_drive", {63'd0, bus_drive}, {63'd0, e.drive});
      check("sel_conflict", {63'd0, sel_conflict}, {63'd0, e.conf});
    end
  endtask

  initial begin
    vecs[0] = '{4'b0001, 8'h5A, 1'b1, 1'b0};
    vecs[1] = '{4'b0010, 8'h11, 1'b1, 1'b0};
    vecs[2] = '{4'b0100, 8'h22, 1'b1, 1'b0};
    vecs[3] = '{4'b1000, 8'hA5, 1'b1, 1'b0};
    vecs[4] = '{4'b0011, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{4'b0000, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{4'b1111, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{4'b0100, 8'h22, 1'b1, 1'b0};

    reset = 1'b1; reset3 = 1'b1;
    ld = '0; sel = '0; src_alu = '0; alu_result = '0; bus_in = '0;
    tick(); tick();
    reset = 1'b0; reset3 = 1'b0;

    check("rst_regs", regs_flat, 0);
    check("rst_bus_out", bus_out, 0);
    check("rst_busy", busy, 0);
    check("rst_drive", bus_drive, 0);
    check("rst_conflict", sel_conflict, 0);
    check("rst_dropped", ld_dropped, 0);
    check("rst_led_ld", led_ld, 0);
    check("rst_led_sel", led_sel, 0);

    // Single ALU load; source changes after the request edge must not matter.
    ld = 4'b0001; src_alu = 4'b0001; alu_result = 8'h5A;
    tick();
    check("ld1_busy_a", busy, 1);
    check("ld1_led_ld", led_ld, 4'b0001);
    ld = '0; alu_result = 8'hFF;
    tick();
    check("ld1_busy_b", busy, 1);
    check("ld1_not_yet", regs_flat, 0);
    tick();
    check("ld1_commit", regs_flat, 32'h0000_005A);
    check("ld1_idle", busy, 0);

    // Back-to-back request right after COMMIT, two sources at once.
    ld = 4'b0110; src_alu = 4'b0010; alu_result = 8'h11; bus_in = 8'h22;
    tick();
    check("mix_accept", busy, 1);
    check("mix_no_drop", ld_dropped, 0);
    check("mix_led_ld", led_ld, 4'b0110);
    ld = '0; alu_result = 8'hEE; bus_in = 8'hDD;
    tick(); tick();
    check("mix_commit", regs_flat, 32'h0022_115A);

    // Request while busy is dropped.
    ld = 4'b1000; src_alu = 4'b0000; bus_in = 8'hA5;
    tick();
    ld = 4'b1000; bus_in = 8'h3C;
    tick();
    check("drop_pulse", ld_dropped, 1);
    ld = '0;
    tick();
    check("drop_pulse_end", ld_dropped, 0);
    check("drop_regs", regs_flat, 32'hA522_115A);
    check("drop_idle", busy, 0);

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      expect_sel(vecs[i].bus, vecs[i].drive, vecs[i].conf);
      tick();
      check("led_sel", led_sel, vecs[i].sel);
    end

    // Load and select the same register: old value through the commit edge.
    sel = 4'b0001; ld = 4'b0001; src_alu = 4'b0001; alu_result = 8'h99;
    expect_sel(8'h5A, 1'b1, 1'b0);
    tick();
    ld = '0; alu_result = 8'h00;
    expect_sel(8'h5A, 1'b1, 1'b0);
    tick();
    expect_sel(8'h5A, 1'b1, 1'b0);
    tick();
    check("cs_commit", regs_flat, 32'hA522_1199);
    expect_sel(8'h99, 1'b1, 1'b0);
    tick();
    sel = '0;
    expect_sel(8'h00, 1'b0, 1'b0);
    tick();
    check("sb_drained", sbq.size(), 0);

    // SETTLE_CYCLES=3 instance: latency, then reset mid-settle.
    reset3 = 1'b1;
    tick();
    reset3 = 1'b0;
    check("d3_rst_regs", d3_regs_flat, 0);
    ld = 4'b0010; src_alu = 4'b0010; alu_result = 8'h42;
    tick();
    ld = '0;
    tick(); tick();
    check("d3_busy_t2", d3_busy, 1);
    check("d3_not_yet", d3_regs_flat, 0);
    tick();
    check("d3_commit", d3_regs_flat, 32'h0000_4200);
    check("d3_idle", d3_busy, 0);

    ld = 4'b0001; src_alu = 4'b0001; alu_result = 8'h77;
    tick();
    ld = '0;
    tick();
    check("d3_settling", d3_busy, 1);
    reset3 = 1'b1;
    tick();
    reset3 = 1'b0;
    check("d3_abort_regs", d3_regs_flat, 0);
    check("d3_abort_busy", d3_busy, 0);
    check("d3_abort_led", d3_led_ld, 0);
    tick(); tick();
    check("d3_no_commit", d3_regs_flat, 0);
    check("d3_still_idle", d3_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/relay_register_bank.md
Name: relay_register_bank

Overview:
- Parametrised register unit holding NUM_REGS general registers of width N. Generalises the single ALU-fed register: each register loads from either the ALU result or the data bus.
- Models relay settling with a programmable load latency and drives the selected register onto the data bus.
- Reports load/select activity to the LED panel and flags bus-select conflicts.
- Sits between the ALU, data bus, control decoder and LED bus in the relay-computer model.

Parameters:
- N, 8, register and bus width in bits.
- NUM_REGS, 4, number of registers (index 0..NUM_REGS-1, e.g. A, B, C, D).
- SETTLE_CYCLES, 2, cycles from accepted load request to commit; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_result  input  N  ALU output, load source when src_alu[i]=1.
- bus_in  input  N  data bus value, load source when src_alu[i]=0.
- ld  input  NUM_REGS  per-register load request (control ldX).
- src_alu  input  NUM_REGS  per-register load source select.
- sel  input  NUM_REGS  per-register bus-select request (control selX).
- bus_out  output  N  value driven onto data bus.
- bus_drive  output  1  bus_out valid / bus enable.
- sel_conflict  output  1  more than one sel bit was high in the previous cycle.
- busy  output  1  a load is pending (settling).
- ld_dropped  output  1  one-cycle pulse: ld request ignored because busy.
- led_ld  output  NUM_REGS  LED: register load pending.
- led_sel  output  NUM_REGS  LED: register selected onto bus.
- regs_flat  output  NUM_REGS*N  all contents; register i at bits [i*N +: N].

Behaviour:
Reset:
- All register contents 0; bus_out 0; bus_drive, sel_conflict, busy and ld_dropped 0; led_ld and led_sel 0.
- FSM enters IDLE.
- Reset asserted mid-settle aborts the pending load; no commit occurs.

Load FSM, states IDLE, SETTLE, COMMIT:
- IDLE: if ld != 0 at an edge, the request is accepted.
  - Capture ld into pend_mask, capture src_alu, capture alu_result into stage_alu and bus_in into stage_bus.
  - Load cnt = SETTLE_CYCLES-1. Go to SETTLE if SETTLE_CYCLES>1, else COMMIT.
- SETTLE: decrement cnt each cycle; when cnt reaches 0, go to COMMIT.
- COMMIT: for every i in pend_mask, content[i] <= stage_alu if captured src_alu[i]=1, else stage_bus. Clear pend_mask; return to IDLE.
- Latency: with a request at edge t, new contents are visible on regs_flat after edge t+SETTLE_CYCLES.
- Data is sampled at the request edge. Later changes on alu_result/bus_in do not affect the committed value.
- Multiple ld bits in one request: all flagged registers commit in the same COMMIT edge, each from its own captured source.
- busy = 1 in SETTLE and COMMIT.
- ld != 0 while busy: request ignored, contents unchanged, ld_dropped = 1 for exactly the next cycle.
- A new request in the cycle after COMMIT is accepted normally; no dead cycle beyond COMMIT.
- led_ld = pend_mask (high from the request edge through the commit edge).

Bus select, registered with 1-cycle latency:
- Exactly one sel bit i high at edge t: bus_out <= content[i] as held before edge t; bus_drive <= 1; sel_conflict <= 0.
- No sel bit high: bus_out <= 0, bus_drive <= 0, sel_conflict <= 0.
- More than one sel bit high: bus_out <= 0, bus_drive <= 0, sel_conflict <= 1.
- Select of a register on its own COMMIT edge returns the old value; the new value appears from the next select edge.
- led_sel <= sel every cycle, including conflict cycles.
- Simultaneous ld and sel on the same register are legal and independent: select reads content, load settles.

Width rules:
- All data paths are exactly N bits; no extension or truncation.
- cnt width is 4 bits.

Test Plan:
- Reset then idle: assert reset 2 cycles with ld=sel=0 -> regs_flat=0, bus_out=0, busy=0, all LEDs 0.
- Single ALU load, N=8, SETTLE_CYCLES=2: ld=0001, src_alu=0001, alu_result=8'h5A for one cycle, alu_result changed to 8'hFF next cycle -> busy high 2 cycles, reg0=8'h5A after 2nd edge, then sel=0001 -> next cycle bus_out=8'h5A, bus_drive=1.
- Mixed multi-load: ld=0110, src_alu=0010, alu_result=8'h11, bus_in=8'h22 -> reg1=8'h11, reg2=8'h22 on the same commit edge; reg0 and reg3 unchanged.
- Busy drop: issue load to reg3 (8'hA5), then ld=1000 with bus_in=8'h3C one cycle later -> ld_dropped pulses 1 cycle, reg3 ends 8'hA5.
- Select conflict: sel=0011 one cycle -> next cycle bus_out=0, bus_drive=0, sel_conflict=1, led_sel=0011; then sel=0000 -> sel_conflict returns to 0.
- Reset mid-settle, SETTLE_CYCLES=3: ld=0001 with alu_result=8'h77, reset asserted on the 2nd settle cycle -> reg0 stays 0, busy=0, led_ld=0 after reset.
